// File: rtl/sound_io_bridge_pkg.sv
// -----------------------------------------------------------------------------
// Package MSX: shared types for the sound I/O bridge.
//   device_t    - identifiers used in the I/O port map and the enable bus
//   io_device_t - one port-map entry {port, mask, id, num}
//   wr_entry_t  - one queued chip write {register/data select, data byte}
//   snd_state_t - per-channel chip-write sequencer state
// -----------------------------------------------------------------------------
package MSX;

   typedef enum logic [3:0] {
      DEV_NONE,
      DEV_OPL3,
      DEV_PSG,
      DEV_SCC,
      DEV_MIDI
   } device_t;

   typedef struct packed {
      logic [7:0] port;
      logic [7:0] mask;
      device_t    id;
      logic [1:0] num;
   } io_device_t;

   typedef struct packed {
      logic       addr;
      logic [7:0] data;
   } wr_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STROBE,
      ST_GAP
   } snd_state_t;

   // Width of the inter-write gap counter (gap lengths up to 255 ticks).
   localparam int GAP_W = 8;

endpackage

// File: rtl/sound_io_bridge_if.sv
// -----------------------------------------------------------------------------
// CPU I/O bus seen by the sound bridge.
//   cpu_iorq, cpu_wr, cpu_m1 - bus cycle qualifiers
//   cpu_addr                 - 8-bit I/O port address
//   cpu_data                 - 8-bit write data
// master: the CPU side (drives everything); slave: the bridge (samples).
// -----------------------------------------------------------------------------
interface sound_io_bridge_if;
   logic       cpu_iorq;
   logic       cpu_wr;
   logic       cpu_m1;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_data;

   modport master (output cpu_iorq, cpu_wr, cpu_m1, cpu_addr, cpu_data);
   modport slave  (input  cpu_iorq, cpu_wr, cpu_m1, cpu_addr, cpu_data);
endinterface

// File: rtl/sound_wr_fifo.sv
// -----------------------------------------------------------------------------
// sound_wr_fifo: per-channel queue of pending chip writes.
//   clk, reset  - system clock, asynchronous active-high reset
//   flush       - empties the queue (wins over push/pop)
//   push, din   - enqueue request; ignored when full unless a pop coincides
//   pop         - dequeue the head entry (ignored when empty)
//   dout        - head entry, valid while !empty
//   empty, full - occupancy status
// Pointers wrap naturally because DEPTH is a power of two.
// -----------------------------------------------------------------------------
module sound_wr_fifo
   import MSX::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      flush,
   input  logic      push,
   input  logic      pop,
   input  wr_entry_t din,
   output wr_entry_t dout,
   output logic      empty,
   output logic      full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   wr_entry_t      mem [DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [AW:0]    count_reg;
   logic           do_pop;
   logic           do_push;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == FULL_CNT);
   assign do_pop  = pop & ~empty;
   // A pop frees the slot this very cycle, so a full queue still accepts.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr_reg];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr_reg] <= din;
   end

endmodule

// File: rtl/sound_io_bridge.sv
// -----------------------------------------------------------------------------
// sound_io_bridge: decodes CPU OUT cycles through the io_device port map,
// queues writes per sound chip, replays them with chip-timed strobes and a
// mandatory idle gap, and mixes the chips' audio.
//   clk, reset            - system clock, asynchronous active-high reset
//   clk_en                - chip clock enable (strobe and gap timing)
//   bus                   - CPU I/O bus (sound_io_bridge_if.slave)
//   io_device[16]         - port map table
//   device/device_num/dev_en - runtime per-channel enable write
//   ovf_clr               - clears all sticky overflow flags
//   chip_cs_n, chip_wr_n  - active-low per-channel strobes
//   chip_addr, chip_din   - per-channel register select and write data
//   chip_snd              - per-chip signed 16-bit audio in
//   ovf                   - sticky queue-overflow flags
//   sound                 - mixed signed 16-bit audio (1 clk latency)
// Build option: SOUND_IO_BRIDGE_SATURATE_EN clamps the mix instead of
// wrapping it to 16 bits.
// -----------------------------------------------------------------------------
module sound_io_bridge
   import MSX::*;
#(
   parameter int      CHANNELS   = 3,
   parameter int      FIFO_DEPTH = 4,
   parameter int      WR_GAP     = 12,
   parameter device_t DEV_NAME   = DEV_OPL3
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clk_en,
   sound_io_bridge_if.slave               bus,
   input  io_device_t                     io_device [16],
   input  device_t                        device,
   input  logic [1:0]                     device_num,
   input  logic                           dev_en,
   input  logic                           ovf_clr,
   output logic [CHANNELS-1:0]            chip_cs_n,
   output logic [CHANNELS-1:0]            chip_wr_n,
   output logic [CHANNELS-1:0]            chip_addr,
   output logic [8*CHANNELS-1:0]          chip_din,
   input  logic signed [16*CHANNELS-1:0]  chip_snd,
   output logic [CHANNELS-1:0]            ovf,
   output logic signed [15:0]             sound
);

   logic                  io_wr;
   logic                  io_wr_prev_reg;
   logic                  io_rise;
   logic                  dev_hit;
   logic [CHANNELS-1:0]   enable_reg;
   logic [CHANNELS-1:0]   dis_now;
   logic [CHANNELS-1:0]   ovf_set;
   logic [CHANNELS-1:0]   ovf_reg;
   wr_entry_t             entry_in;
   logic signed [17:0]    mix;
   logic signed [15:0]    mix_out;
   logic signed [15:0]    sound_reg;

   assign io_wr    = bus.cpu_iorq & bus.cpu_wr & ~bus.cpu_m1;
   assign io_rise  = io_wr & ~io_wr_prev_reg;
   assign entry_in = {bus.cpu_addr[0], bus.cpu_data};
   assign dev_hit  = (device == DEV_NAME) && (int'(device_num) < CHANNELS);
   assign ovf      = ovf_reg;
   assign sound    = sound_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         io_wr_prev_reg <= 1'b0;
         enable_reg     <= '1;
         ovf_reg        <= '0;
         sound_reg      <= '0;
      end else begin
         io_wr_prev_reg <= io_wr;
         for (int i = 0; i < CHANNELS; i++)
            if (dev_hit && int'(device_num) == i) enable_reg[i] <= dev_en;
         // A new overflow outranks a simultaneous clear.
         ovf_reg   <= (ovf_reg & ~{CHANNELS{ovf_clr}}) | ovf_set;
         sound_reg <= mix_out;
      end
   end

   always_comb begin
      mix = '0;
      for (int i = 0; i < CHANNELS; i++)
         if (enable_reg[i])
            mix = mix + {{2{chip_snd[16*i+15]}}, chip_snd[16*i +: 16]};
`ifdef SOUND_IO_BRIDGE_SATURATE_EN
      if (mix > 18'sd32767)
         mix_out = 16'sh7FFF;
      else if (mix < -18'sd32768)
         mix_out = 16'sh8000;
      else
         mix_out = mix[15:0];
`else
      mix_out = mix[15:0];
`endif
   end

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic                match_hit;
         logic                push_ch;
         logic                pop_ch;
         logic                fifo_empty;
         logic                fifo_full;
         wr_entry_t           head;
         snd_state_t          state_reg;
         logic [GAP_W-1:0]    gap_cnt_reg;
         logic                cs_reg;
         logic                wr_reg;
         logic                addr_reg;
         logic [7:0]          din_reg;

         // Any table entry for this device and channel that claims the port.
         always_comb begin
            match_hit = 1'b0;
            for (int i = 0; i < 16; i++)
               if (((bus.cpu_addr & io_device[i].mask) == io_device[i].port) &&
                   (io_device[i].id == DEV_NAME) &&
                   (io_device[i].num == 2'(gi)))
                  match_hit = 1'b1;
         end

         assign dis_now[gi] = dev_hit && (device_num == 2'(gi)) && !dev_en;
         assign push_ch     = io_rise & match_hit & enable_reg[gi];
         assign pop_ch      = (state_reg == ST_STROBE) && clk_en;
         assign ovf_set[gi] = push_ch & fifo_full & ~pop_ch & ~dis_now[gi];

         sound_wr_fifo #(
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (dis_now[gi]),
            .push  (push_ch),
            .pop   (pop_ch),
            .din   (entry_in),
            .dout  (head),
            .empty (fifo_empty),
            .full  (fifo_full)
         );

         // The head entry is latched on entry to STROBE and popped on the
         // tick that ends it, so the next head is ready when GAP expires.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               state_reg   <= ST_IDLE;
               gap_cnt_reg <= '0;
               cs_reg      <= 1'b1;
               wr_reg      <= 1'b1;
               addr_reg    <= 1'b0;
               din_reg     <= '0;
            end else if (dis_now[gi] || !enable_reg[gi]) begin
               state_reg   <= ST_IDLE;
               gap_cnt_reg <= '0;
               cs_reg      <= 1'b1;
               wr_reg      <= 1'b1;
            end else begin
               case (state_reg)
                  ST_IDLE: begin
                     if (!fifo_empty) begin
                        state_reg <= ST_STROBE;
                        cs_reg    <= 1'b0;
                        wr_reg    <= 1'b0;
                        addr_reg  <= head.addr;
                        din_reg   <= head.data;
                     end
                  end
                  ST_STROBE: begin
                     if (clk_en) begin
                        state_reg   <= ST_GAP;
                        cs_reg      <= 1'b1;
                        wr_reg      <= 1'b1;
                        gap_cnt_reg <= GAP_W'(WR_GAP);
                     end
                  end
                  ST_GAP: begin
                     if (clk_en) begin
                        if (gap_cnt_reg <= GAP_W'(1)) begin
                           gap_cnt_reg <= '0;
                           if (!fifo_empty) begin
                              state_reg <= ST_STROBE;
                              cs_reg    <= 1'b0;
                              wr_reg    <= 1'b0;
                              addr_reg  <= head.addr;
                              din_reg   <= head.data;
                           end else begin
                              state_reg <= ST_IDLE;
                           end
                        end else begin
                           gap_cnt_reg <= gap_cnt_reg - 1'b1;
                        end
                     end
                  end
                  default: state_reg <= ST_IDLE;
               endcase
            end
         end

         assign chip_cs_n[gi]       = cs_reg;
         assign chip_wr_n[gi]       = wr_reg;
         assign chip_addr[gi]       = addr_reg;
         assign chip_din[8*gi +: 8] = din_reg;
      end
   endgenerate

endmodule

// File: tb/tb_sound_io_bridge.sv
// -----------------------------------------------------------------------------
// Testbench for sound_io_bridge (3 channels, 4-deep queues, 12-tick gap).
// Expected chip writes come from a port-map model and per-channel queues;
// expected audio comes from integer summation with wrap or clamp.
// -----------------------------------------------------------------------------
module tb_sound_io_bridge;
   import MSX::*;

   localparam int CH     = 3;
   localparam int WR_GAP = 12;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               clk_en = 1'b0;
   device_t            device;
   logic [1:0]         device_num;
   logic               dev_en;
   logic               ovf_clr;
   io_device_t         io_dev [16];
   logic [CH-1:0]      chip_cs_n, chip_wr_n, chip_addr, ovf;
   logic [8*CH-1:0]    chip_din;
   logic signed [16*CH-1:0] chip_snd;
   logic signed [15:0] sound;

   sound_io_bridge_if bus_if ();

   sound_io_bridge #(
      .CHANNELS   (CH),
      .FIFO_DEPTH (4),
      .WR_GAP     (WR_GAP),
      .DEV_NAME   (DEV_OPL3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clk_en     (clk_en),
      .bus        (bus_if.slave),
      .io_device  (io_dev),
      .device     (device),
      .device_num (device_num),
      .dev_en     (dev_en),
      .ovf_clr    (ovf_clr),
      .chip_cs_n  (chip_cs_n),
      .chip_wr_n  (chip_wr_n),
      .chip_addr  (chip_addr),
      .chip_din   (chip_din),
      .chip_snd   (chip_snd),
      .ovf        (ovf),
      .sound      (sound)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [8:0]  exp_q [3][$];
   bit          en_model [3];
   int          writes_seen [3];
   bit          have_end [3];
   int          end_tick [3];
   logic [2:0]  prev_cs = 3'b111;
   int          ticks = 0;
   int          div = 0;
   bit          clk_en_run = 1'b1;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // clk_en every third clock unless paused.
   always @(negedge clk) begin
      if (clk_en_run) begin
         div    = (div == 2) ? 0 : div + 1;
         clk_en = (div == 0);
      end else begin
         clk_en = 1'b0;
      end
   end

   always @(posedge clk) if (clk_en) ticks++;

   // Write monitor: every falling chip_cs_n is one chip write.
   always @(negedge clk) begin
      if (reset) begin
         prev_cs = 3'b111;
         for (int c = 0; c < CH; c++) have_end[c] = 1'b0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (prev_cs[c] && !chip_cs_n[c]) begin
               writes_seen[c]++;
               $display("write ch%0d addr=%0d data=%02h", c, chip_addr[c], chip_din[8*c +: 8]);
               check($sformatf("wr_n_ch%0d", c), int'(chip_wr_n[c]), 0);
               if (exp_q[c].size() == 0) begin
                  check($sformatf("unexpected_write_ch%0d", c), 1, 0);
               end else begin
                  check($sformatf("write_ch%0d", c),
                        int'({chip_addr[c], chip_din[8*c +: 8]}), int'(exp_q[c].pop_front()));
               end
               if (have_end[c]) begin
                  vectors++;
                  if (ticks - end_tick[c] < WR_GAP) begin
                     miscompares++;
                     $display("FAIL gap_ch%0d: %0d ticks, need >= %0d", c, ticks - end_tick[c], WR_GAP);
                  end
               end
            end
            if (!prev_cs[c] && chip_cs_n[c]) begin
               end_tick[c] = ticks;
               have_end[c] = 1'b1;
            end
            prev_cs[c] = chip_cs_n[c];
         end
      end
   end

   function automatic bit port_match(input logic [7:0] a, input int c);
      for (int i = 0; i < 16; i++)
         if (((a & io_dev[i].mask) == io_dev[i].port) && io_dev[i].id == DEV_OPL3 &&
             int'(io_dev[i].num) == c)
            return 1'b1;
      return 1'b0;
   endfunction

   function automatic int mix_ref(input int s0, input int s1, input int s2, input bit e0,
                                  input bit e1, input bit e2);
      int sum;
      int w;
      sum = (e0 ? s0 : 0) + (e1 ? s1 : 0) + (e2 ? s2 : 0);
`ifdef SOUND_IO_BRIDGE_SATURATE_EN
      if (sum > 32767) return 32767;
      if (sum < -32768) return -32768;
      w = sum;
`else
      w = sum % 65536;
      if (w < 0) w += 65536;
      if (w >= 32768) w -= 65536;
`endif
      return w;
   endfunction

   // One OUT bus cycle held for 'hold' clocks; accept=0 means the model
   // expects the entry to be dropped.
   task automatic do_out(input logic [7:0] a, input logic [7:0] d, input int hold,
                         input bit accept, input bit clr, input bit m1);
      for (int c = 0; c < CH; c++)
         if (port_match(a, c) && en_model[c] && accept && !m1) exp_q[c].push_back({a[0], d});
      @(negedge clk);
      bus_if.cpu_iorq = 1'b1;
      bus_if.cpu_wr   = 1'b1;
      bus_if.cpu_m1   = m1;
      bus_if.cpu_addr = a;
      bus_if.cpu_data = d;
      ovf_clr         = clr;
      repeat (hold) @(negedge clk);
      bus_if.cpu_iorq = 1'b0;
      bus_if.cpu_wr   = 1'b0;
      bus_if.cpu_m1   = 1'b0;
      ovf_clr         = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_en(input int c, input bit e);
      @(negedge clk);
      device     = DEV_OPL3;
      device_num = 2'(c);
      dev_en     = e;
      @(negedge clk);
      device     = DEV_NONE;
      en_model[c] = e;
   endtask

   task automatic set_snd(input int s0, input int s1, input int s2);
      chip_snd[15:0]  = 16'(s0);
      chip_snd[31:16] = 16'(s1);
      chip_snd[47:32] = 16'(s2);
   endtask

   task automatic wait_cs(input int c, input logic lvl, input string name);
      bit hit = 1'b0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         @(negedge clk);
         if (chip_cs_n[c] == lvl) hit = 1'b1;
      end
      check(name, int'(hit), 1);
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int i = 0; i < 4000 && !done; i++) begin
         @(negedge clk);
         if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 &&
             chip_cs_n == 3'b111)
            done = 1'b1;
      end
      check("drain", int'(done), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cs_n"}, int'(chip_cs_n), 7);
      check({tag, "_wr_n"}, int'(chip_wr_n), 7);
      check({tag, "_addr"}, int'(chip_addr), 0);
      check({tag, "_din"},  int'(chip_din), 0);
      check({tag, "_ovf"},  int'(ovf), 0);
      check({tag, "_sound"}, int'(sound), 0);
   endtask

   typedef struct {
      logic [2:0] en;
      int         s0, s1, s2;
      int         exp_wrap, exp_sat;
   } mix_vec_t;

   mix_vec_t    tbl [8];
   logic [7:0]  ports [11];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base [3];
      int exp;
      int s [3];
      logic [2:0] em;

      tbl[0] = '{3'b111,    100,    200,    300,    600,    600};
      tbl[1] = '{3'b111,  30000,  30000,  30000,  24464,  32767};
      tbl[2] = '{3'b111, -30000, -30000, -30000, -24464, -32768};
      tbl[3] = '{3'b101,  30000,  30000,   5000, -30536,  32767};
      tbl[4] = '{3'b010, -32768, -32768, -32768, -32768, -32768};
      tbl[5] = '{3'b000,  12345,  -1000,    777,      0,      0};
      tbl[6] = '{3'b111,  32767,      1,     -1,  32767,  32767};
      tbl[7] = '{3'b011,  32767,      1,   9999, -32768,  32767};
      ports = '{8'h7C, 8'h7D, 8'hC0, 8'hC1, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'h10, 8'h33, 8'h7E};

      for (int i = 0; i < 16; i++) io_dev[i] = '{8'h00, 8'h00, DEV_NONE, 2'd0};
      io_dev[0] = '{8'h7C, 8'hFE, DEV_OPL3, 2'd1};
      io_dev[1] = '{8'hC0, 8'hFE, DEV_OPL3, 2'd0};
      io_dev[2] = '{8'hC4, 8'hFC, DEV_OPL3, 2'd2};
      io_dev[3] = '{8'h7C, 8'hFE, DEV_PSG,  2'd0};
      io_dev[4] = '{8'h10, 8'hF0, DEV_OPL3, 2'd3};
      io_dev[5] = '{8'hC4, 8'hFE, DEV_OPL3, 2'd0};

      bus_if.cpu_iorq = 1'b0;
      bus_if.cpu_wr   = 1'b0;
      bus_if.cpu_m1   = 1'b0;
      bus_if.cpu_addr = 8'h00;
      bus_if.cpu_data = 8'h00;
      device = DEV_NONE; device_num = 2'd0; dev_en = 1'b0; ovf_clr = 1'b0;
      set_snd(0, 0, 0);
      for (int c = 0; c < CH; c++) begin en_model[c] = 1'b1; writes_seen[c] = 0; end

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;

      // Two writes to channel 1 through the 0x7C/0x7D pair
      do_out(8'h7C, 8'h20, 1, 1, 0, 0);
      do_out(8'h7D, 8'h55, 1, 1, 0, 0);
      drain();
      check("basic_ch0_writes", writes_seen[0], 0);
      check("basic_ch1_writes", writes_seen[1], 2);
      check("basic_ch2_writes", writes_seen[2], 0);

      // M1 cycle is not an I/O write; a 10-clock strobe pushes once
      do_out(8'h7C, 8'h66, 2, 1, 0, 1);
      do_out(8'h7C, 8'h99, 10, 1, 0, 0);
      drain();
      check("long_strobe_writes", writes_seen[1], 3);

      // Overflow on channel 0: 1 in flight + 4 queued, 6th dropped
      base[0] = writes_seen[0];
      for (int i = 0; i < 5; i++) do_out(8'hC0, 8'h30 + 8'(i), 1, 1, 0, 0);
      check("ovf_before", int'(ovf), 0);
      do_out(8'hC1, 8'h3F, 1, 0, 1, 0);
      check("ovf_set_wins", int'(ovf), 1);
      @(negedge clk); ovf_clr = 1'b1;
      @(negedge clk); ovf_clr = 1'b0;
      check("ovf_cleared", int'(ovf), 0);
      drain();
      check("ovf_writes", writes_seen[0] - base[0], 5);

      // Mixer table
      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < CH; c++) set_en(c, tbl[i].en[c]);
         set_snd(tbl[i].s0, tbl[i].s1, tbl[i].s2);
         @(negedge clk);
`ifdef SOUND_IO_BRIDGE_SATURATE_EN
         exp = tbl[i].exp_sat;
`else
         exp = tbl[i].exp_wrap;
`endif
         $display("mix vector %0d en=%b -> %0d", i, tbl[i].en, sound);
         check($sformatf("mix_tbl%0d", i), int'(sound), exp);
      end
      for (int c = 0; c < CH; c++) set_en(c, 1'b1);

      // Enable write for another device id is ignored
      @(negedge clk);
      device = DEV_PSG; device_num = 2'd0; dev_en = 1'b0;
      @(negedge clk);
      device = DEV_NONE;
      set_snd(1234, 0, 0);
      @(negedge clk);
      check("foreign_dev_ignored", int'(sound), 1234);

      // Disabling channel 2 during a strobe
      base[0] = writes_seen[0];
      base[2] = writes_seen[2];
      clk_en_run = 1'b0;
      do_out(8'hC6, 8'hA1, 1, 1, 0, 0);
      do_out(8'hC6, 8'hA2, 1, 1, 0, 0);
      wait_cs(2, 1'b0, "abort_strobe_seen");
      @(posedge clk); #1;
      device = DEV_OPL3; device_num = 2'd2; dev_en = 1'b0;
      en_model[2] = 1'b0;
      exp_q[2].delete();
      @(posedge clk); #1;
      device = DEV_NONE;
      check("abort_cs_n", int'(chip_cs_n[2]), 1);
      check("abort_wr_n", int'(chip_wr_n[2]), 1);
      @(negedge clk);
      have_end[2] = 1'b0;
      clk_en_run = 1'b1;
      do_out(8'hC6, 8'h11, 1, 1, 0, 0);
      do_out(8'hC4, 8'h22, 1, 1, 0, 0);
      drain();
      check("abort_ch2_writes", writes_seen[2] - base[2], 1);
      check("abort_ch0_writes", writes_seen[0] - base[0], 1);
      set_snd(5, 0, 1000);
      @(negedge clk);
      check("abort_mix", int'(sound), mix_ref(5, 0, 1000, en_model[0], en_model[1], en_model[2]));
      set_en(2, 1'b1);
      repeat (60) @(negedge clk);
      drain();
      check("flushed_ch2_writes", writes_seen[2] - base[2], 1);

      // Random bursts (at most 4 OUTs, so no queue can overflow)
      for (int b = 0; b < 15; b++) begin
         int n;
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++)
            do_out(ports[$urandom_range(0, 10)], 8'($urandom), $urandom_range(1, 3), 1, 0,
                   ($urandom_range(0, 7) == 0));
         repeat ($urandom_range(0, 20)) @(negedge clk);
         drain();
      end

      // Random mix with random enables
      for (int i = 0; i < 40; i++) begin
         em = 3'($urandom);
         for (int c = 0; c < CH; c++) begin
            set_en(c, em[c]);
            s[c] = $urandom_range(0, 65535) - 32768;
         end
         set_snd(s[0], s[1], s[2]);
         @(negedge clk);
         check($sformatf("mix_rand%0d", i), int'(sound),
               mix_ref(s[0], s[1], s[2], en_model[0], en_model[1], en_model[2]));
      end
      for (int c = 0; c < CH; c++) set_en(c, 1'b1);

      // Asynchronous reset in the middle of a gap
      do_out(8'h7C, 8'hAB, 1, 1, 0, 0);
      wait_cs(1, 1'b0, "rst_strobe_seen");
      wait_cs(1, 1'b1, "rst_gap_seen");
      set_snd(100, 200, 300);
      repeat (3) @(negedge clk);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < CH; c++) begin en_model[c] = 1'b1; exp_q[c].delete(); end
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
